// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared definitions for the clock-divider phase checker.
//               Contains the FSM state encoding, the phase vector width,
//               parameter defaults and the phase-step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

   // Checker FSM state encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      FAULT   = 2'd3
   } state_t;

   // Width of the sampled vector {clkf, clk2f, clk4f}
   localparam int PHASE_W      = 3;

   // Parameter defaults for the checker
   localparam int LOCK_CNT_DEF = 4;
   localparam int ERR_W_DEF    = 8;

   // Expected successor of a phase sample; 3'b111 wraps to 3'b000
   function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
      return p + 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Width-parameterized up-counter with increment enable,
//               synchronous clear and saturation at all-ones (never wraps).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;

   // Count enabled increments, holding at the maximum value once reached
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != c_MAX)) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/clk_div_checker.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_checker
// Description : Verifies that three divided clocks (/8, /4, /2), generated in
//               the clk8f domain, form a binary counter {clkf,clk2f,clk4f}
//               that advances by exactly one every clk8f edge. Reports lock,
//               a violation flag and a saturating violation count.
// Config      : CLK_DIV_CHECKER_STICKY_EN - when defined, error stays high
//               from the first violation until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_checker
   import clk_div_pkg::*;
#(
   parameter int LOCK_CNT = LOCK_CNT_DEF,
   parameter int ERR_W    = ERR_W_DEF
) (
   input  logic               clk8f,
   input  logic               reset,
   input  logic               clkf_in,
   input  logic               clk2f_in,
   input  logic               clk4f_in,
   output logic               locked,
   output logic               error,
   output logic [PHASE_W-1:0] phase,
   output logic [ERR_W-1:0]   err_count
);

   // Run counter is 4 bits since LOCK_CNT is limited to 1..15
   localparam logic [3:0] c_LOCK_RUN = LOCK_CNT[3:0];

   state_t             r_state;
   logic               r_locked;
   logic               r_error;
   logic [PHASE_W-1:0] r_phase;
   logic [3:0]         r_run;
   logic               r_prev_valid;

   logic [PHASE_W-1:0] w_sample;
   logic               w_step_ok;
   logic [3:0]         w_run_inc;
   logic               w_fault_entry;
   logic               w_error_keep;

   // Inputs already live in the clk8f domain, so they are sampled directly
   assign w_sample      = {clkf_in, clk2f_in, clk4f_in};
   assign w_step_ok     = r_prev_valid && (w_sample == next_phase(r_phase));
   assign w_run_inc     = r_run + 4'd1;
   assign w_fault_entry = (r_state == LOCKED) && !w_step_ok;

`ifdef CLK_DIV_CHECKER_STICKY_EN
   assign w_error_keep = r_error;
`else
   assign w_error_keep = 1'b0;
`endif

   // Phase sampling, step checking FSM and registered status outputs
   always_ff @(posedge clk8f) begin
      if (reset) begin
         r_state      <= IDLE;
         r_locked     <= 1'b0;
         r_error      <= 1'b0;
         r_phase      <= '0;
         r_run        <= 4'd0;
         r_prev_valid <= 1'b0;
      end else begin
         r_phase <= w_sample;
         r_error <= w_error_keep;
         case (r_state)
            IDLE: begin
               // First sample only establishes the reference; no step checked
               r_prev_valid <= 1'b1;
               r_run        <= 4'd0;
               r_state      <= ACQUIRE;
            end
            ACQUIRE: begin
               if (w_step_ok) begin
                  r_run <= w_run_inc;
                  if (w_run_inc == c_LOCK_RUN) begin
                     r_state  <= LOCKED;
                     r_locked <= 1'b1;
                  end
               end else begin
                  // Violations while acquiring only restart the run
                  r_run <= 4'd0;
               end
            end
            LOCKED: begin
               if (!w_step_ok) begin
                  r_state  <= FAULT;
                  r_locked <= 1'b0;
                  r_error  <= 1'b1;
               end
            end
            FAULT: begin
               // The step sampled here is ignored; reacquire from scratch
               r_state <= ACQUIRE;
               r_run   <= 4'd0;
            end
            default: begin
               r_state  <= IDLE;
               r_locked <= 1'b0;
               r_run    <= 4'd0;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH (ERR_W)
   ) u_err_cnt (
      .clk     (clk8f),
      .rst     (reset),
      .i_inc   (w_fault_entry),
      .i_clr   (1'b0),
      .o_count (err_count)
   );

   assign locked = r_locked;
   assign error  = r_error;
   assign phase  = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_checker
// Description : Directed self-checking bench for clk_div_checker. A second
//               instance with ERR_W=2 shares the stimulus to exercise
//               error-counter saturation.
// Config      : CLK_DIV_CHECKER_STICKY_EN - selects sticky error expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_checker;

`ifdef CLK_DIV_CHECKER_STICKY_EN
   localparam bit c_STICKY = 1'b1;
`else
   localparam bit c_STICKY = 1'b0;
`endif

   logic       clk8f = 1'b0;
   logic       reset = 1'b1;
   logic       clkf_in = 1'b0;
   logic       clk2f_in = 1'b0;
   logic       clk4f_in = 1'b0;

   logic       locked,  error;
   logic [2:0] phase;
   logic [7:0] err_count;

   logic       locked2, error2;
   logic [2:0] phase2;
   logic [1:0] err_count2;

   int checks = 0;
   int errors = 0;

   logic [2:0] ph;

   clk_div_checker #(.LOCK_CNT(4), .ERR_W(8)) dut (
      .clk8f     (clk8f),
      .reset     (reset),
      .clkf_in   (clkf_in),
      .clk2f_in  (clk2f_in),
      .clk4f_in  (clk4f_in),
      .locked    (locked),
      .error     (error),
      .phase     (phase),
      .err_count (err_count)
   );

   clk_div_checker #(.LOCK_CNT(4), .ERR_W(2)) dut2 (
      .clk8f     (clk8f),
      .reset     (reset),
      .clkf_in   (clkf_in),
      .clk2f_in  (clk2f_in),
      .clk4f_in  (clk4f_in),
      .locked    (locked2),
      .error     (error2),
      .phase     (phase2),
      .err_count (err_count2)
   );

   always #5 clk8f = ~clk8f;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one vector, let one edge pass, then settle 1 time unit
   task automatic tick(input logic [2:0] v);
      {clkf_in, clk2f_in, clk4f_in} = v;
      @(posedge clk8f);
      #1;
   endtask

   // Ideal reacquire after a fault edge: 4 correct steps, lock on the 4th
   task automatic relock(input string tag);
      for (int i = 1; i <= 4; i++) begin
         tick(ph);
         ph = ph + 3'd1;
         check({tag, "_locked"}, {31'd0, locked}, {31'd0, (i == 4)});
      end
   endtask

   initial begin
      // Reset state
      @(posedge clk8f); #1;
      tick(3'd5);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_error",  {31'd0, error},  32'd0);
      check("rst_phase",  {29'd0, phase},  32'd0);
      check("rst_errcnt", {24'd0, err_count}, 32'd0);
      check("rst_state",  {30'd0, dut.r_state}, 32'd0);

      // Initial acquisition: lock on the 5th edge after release
      reset = 1'b0;
      ph = 3'd0;
      for (int i = 1; i <= 5; i++) begin
         tick(ph);
         ph = ph + 3'd1;
         check("acq_locked", {31'd0, locked}, {31'd0, (i == 5)});
         check("acq_error",  {31'd0, error},  32'd0);
      end
      check("acq_phase",  {29'd0, phase}, 32'd4);
      check("acq_errcnt", {24'd0, err_count}, 32'd0);
      check("acq_state",  {30'd0, dut.r_state}, 32'd2);

      // 200 ideal cycles covering every 7->0 wrap
      for (int i = 0; i < 200; i++) begin
         tick(ph);
         ph = ph + 3'd1;
         check("wrap_locked", {31'd0, locked}, 32'd1);
         check("wrap_error",  {31'd0, error},  32'd0);
      end

      // Repeated 5,5 while locked
      while (ph != 3'd5) begin
         tick(ph);
         ph = ph + 3'd1;
      end
      tick(3'd5);
      ph = 3'd6;
      tick(3'd5);
      check("v1_error",   {31'd0, error},  32'd1);
      check("v1_locked",  {31'd0, locked}, 32'd0);
      check("v1_errcnt",  {24'd0, err_count}, 32'd1);
      check("v1_phase",   {29'd0, phase}, 32'd5);
      check("v1_state",   {30'd0, dut.r_state}, 32'd3);
      // FAULT edge: sample not checked, error pulse ends unless sticky
      tick(ph);
      ph = ph + 3'd1;
      check("v1f_error",  {31'd0, error}, {31'd0, c_STICKY});
      check("v1f_state",  {30'd0, dut.r_state}, 32'd1);
      // Acquire-phase violation: restarts run, no error counted
      tick(ph);
      ph = ph + 3'd1;
      tick(ph + 3'd2);
      ph = ph + 3'd3;
      check("acqv_errcnt", {24'd0, err_count}, 32'd1);
      check("acqv_locked", {31'd0, locked}, 32'd0);
      relock("v1");
      check("v1r_error",  {31'd0, error}, {31'd0, c_STICKY});

      // Four more violations: saturation of the 2-bit counter
      for (int k = 2; k <= 5; k++) begin
         tick(ph - 3'd1);
         check("vk_errcnt8", {24'd0, err_count}, k);
         check("vk_errcnt2", {30'd0, err_count2}, (k > 3) ? 32'd3 : k);
         check("vk_error",   {31'd0, error}, 32'd1);
         tick(ph);
         ph = ph + 3'd1;
         relock("vk");
      end

      // Sticky/pulse behaviour across 20 ideal cycles
      for (int i = 0; i < 20; i++) begin
         tick(ph);
         ph = ph + 3'd1;
         check("idl_error",  {31'd0, error},  {31'd0, c_STICKY});
         check("idl_locked", {31'd0, locked}, 32'd1);
      end

      // Mid-operation reset while locked
      reset = 1'b1;
      tick(ph);
      ph = ph + 3'd1;
      check("mrst_locked", {31'd0, locked}, 32'd0);
      check("mrst_error",  {31'd0, error},  32'd0);
      check("mrst_errcnt", {24'd0, err_count}, 32'd0);
      check("mrst_errc2",  {30'd0, err_count2}, 32'd0);
      check("mrst_phase",  {29'd0, phase}, 32'd0);
      check("mrst_state",  {30'd0, dut.r_state}, 32'd0);

      // Restart from IDLE after release
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick(ph);
         ph = ph + 3'd1;
         check("re_locked", {31'd0, locked}, {31'd0, (i == 5)});
      end
      check("re_error", {31'd0, error}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clk_div_checker.md
CLK_DIV_CHECKER -- requirements
Module: clk_div_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4, meaning consecutive correct steps required to declare lock (legal range 1..15).
REQ-002 The block SHALL have parameter ERR_W, default 8, meaning width of the saturating error counter.
REQ-003 Port clk8f, input, 1 bit: sole clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port clkf_in, input, 1 bit: divide-by-8 clock under test, generated in the clk8f domain.
REQ-006 Port clk2f_in, input, 1 bit: divide-by-4 clock under test.
REQ-007 Port clk4f_in, input, 1 bit: divide-by-2 clock under test.
REQ-008 Port locked, output, 1 bit: high while the phase relation is verified.
REQ-009 Port error, output, 1 bit: a phase violation was detected.
REQ-010 Port phase, output, 3 bits: last sampled vector {clkf_in, clk2f_in, clk4f_in}.
REQ-011 Port err_count, output, ERR_W bits: number of violations detected since reset.

Function
REQ-012 On each clk8f rising edge the block SHALL register s = {clkf_in, clk2f_in, clk4f_in} into phase, with no synchronizer, since the inputs share the clk8f domain.
REQ-013 A step is correct when the new s equals (previous s + 1) mod 8; any other value, including no change, is a violation.
REQ-014 The FSM SHALL have states IDLE, ACQUIRE, LOCKED and FAULT.
REQ-015 IDLE: the block captures the first sample, sets an internal prev_valid flag and moves to ACQUIRE on the next edge; no step is checked in IDLE.
REQ-016 ACQUIRE: a correct step increments a run counter; a violation clears the run counter to 0, does not count as an error, and stays in ACQUIRE.
REQ-017 ACQUIRE to LOCKED: when the run counter reaches LOCK_CNT, the FSM enters LOCKED; locked is registered and goes high on that same edge.
REQ-018 LOCKED: correct steps keep the FSM in LOCKED; a violation moves it to FAULT.
REQ-019 On entering FAULT, locked SHALL drop, error SHALL pulse high for exactly one cycle, and err_count SHALL increment.
REQ-020 FAULT SHALL last exactly one cycle, then go to ACQUIRE with the run counter at 0; the step sampled while in FAULT SHALL NOT be checked.
REQ-021 err_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-022 Wrap-around: the step 3'b111 to 3'b000 is correct.
REQ-023 Detection latency: error and the locked drop appear on the same edge that samples the offending vector, one register stage after the inputs change.

Reset
REQ-024 While reset is high at a clk8f edge, the block SHALL set state=IDLE, locked=0, error=0, phase=3'b000, err_count=0, run counter=0 and prev_valid=0.
REQ-025 Reset asserted mid-operation in any state SHALL take effect on the next edge and override all other updates.
REQ-026 Checking SHALL restart from IDLE on the first edge with reset low.

Configuration
REQ-027 Macro CLK_DIV_CHECKER_STICKY_EN: when defined, error SHALL be sticky, staying high from the first violation until reset; FSM behaviour and err_count are unchanged.
REQ-028 When CLK_DIV_CHECKER_STICKY_EN is not defined, error SHALL be the one-cycle pulse of REQ-019.

Structure
REQ-029 A shared package clk_div_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2, FAULT=2'd3), the constant PHASE_W=3, and the LOCK_CNT and ERR_W defaults.
REQ-030 One sub-module sat_counter (width-parameterized, increment enable, synchronous clear, saturation) SHALL implement err_count; the FSM and step comparator stay in clk_div_checker.

Verification
REQ-031 Ideal divider, reset released at edge 3, phase counting 0,1,2,... -> locked rises on the 5th edge after reset release (IDLE + ACQUIRE + 4 correct steps, LOCK_CNT=4); error never high; err_count=0.
REQ-032 Locked, clk4f_in held one extra cycle so phase repeats 5,5 -> error pulses one cycle on the edge sampling the second 5; locked=0; err_count=1; relock 4 correct steps after the FAULT cycle.
REQ-033 Wrap check: 200 consecutive ideal cycles including every 7 to 0 transition -> locked stays 1 throughout.
REQ-034 ERR_W=2 with 5 injected violations, each separated by relock -> err_count reads 1, 2, 3, 3, 3.
REQ-035 Reset asserted for one edge while LOCKED with err_count=2 -> next edge shows locked=0, err_count=0, phase=0, state=IDLE.
REQ-036 CLK_DIV_CHECKER_STICKY_EN defined, one violation then 20 ideal cycles -> error stays 1 and locked returns to 1; error clears only on reset.
